dac_waveform_player: RTL and testbench
======================================

Name: dac_waveform_player

Overview:
Arbitrary-waveform playback engine that sits directly upstream of the DAC monitor/AXIS stage and drives its dacN_data input.
- Software or a loader writes multi-sample words into an internal BRAM through a simple write port.
- The engine replays words 0..last_addr at one word per clock, once, N times, or forever.
- Outside playback it outputs zero, which is mid-scale for two's-complement DAC codes.

Parameters:
NUMBER_OF_LINE, 8, samples per clock word; each sample is 16 bits.
ADDR_WIDTH, 10, waveform memory address width; depth is 2**ADDR_WIDTH words.

Ports:
clock  input  1  single clock for the whole block (DAC fabric clock, 500 MHz).
reset  input  1  synchronous, active-high reset.
wr_en  input  1  write strobe for waveform memory.
wr_addr  input  ADDR_WIDTH  write address.
wr_data  input  16*NUMBER_OF_LINE  write word; sample 0 occupies bits [15:0].
last_addr  input  ADDR_WIDTH  final address of the waveform; sampled on start.
loop_count  input  16  number of passes; 0 = infinite; sampled on start.
start  input  1  begin playback; level-sampled, honoured only in IDLE.
stop  input  1  abort playback; honoured only in PLAY.
dac_data  output  16*NUMBER_OF_LINE  word to DAC stage; zero when not valid.
dac_data_valid  output  1  high when dac_data carries a waveform word.
busy  output  1  high from PLAY entry until the last word has been output.
done  output  1  single-cycle pulse on the first cycle after the last output word.

Behaviour:
Reset values:
- dac_data = 0, dac_data_valid = 0, busy = 0, done = 0.
- State = IDLE; rd_addr = 0; pass counter = 0.
- Memory contents are NOT cleared by reset.

Memory:
- Simple dual-port, 2**ADDR_WIDTH x 16*NUMBER_OF_LINE, registered read (BRAM inference).
- Writes are accepted in any state, including during PLAY.
- A read and write to the same address in the same cycle returns the old data (read-first).

State machine:
- IDLE: when start = 1 in cycle n, latch last_addr and loop_count, clear the pass counter, set rd_addr = 0, and go to PLAY at n+1.
- PLAY: issue rd_addr each cycle.
  - If rd_addr == last_addr and the pass is not the final one, rd_addr wraps to 0 and the pass counter increments.
  - The final pass is reached when latched loop_count != 0 and pass counter + 1 == loop_count. On its last address, go to IDLE next cycle.
  - Otherwise rd_addr increments by 1.
- stop = 1 in cycle m while in PLAY: go to IDLE at m+1. The address issued in cycle m is still output; no further addresses are issued.

Pipeline and latency:
- An address issued in cycle c appears on dac_data with dac_data_valid = 1 in cycle c+1.
- So start in cycle n gives word 0 at n+2, and word k at n+2+k in the first pass.
- No gaps at wrap: word last_addr is followed immediately by word 0.
- When dac_data_valid = 0, dac_data is forced to 0.

Status outputs:
- busy = (state == PLAY) OR dac_data_valid.
- done pulses for one cycle in the first cycle where busy falls. This applies to both natural completion and stop.

Boundary cases:
- last_addr = 0: the single word repeats for the requested number of passes.
- loop_count = 0: plays until stop or reset.
- The pass counter is 16 bits; it never wraps for finite counts, and is don't-care in infinite mode.
- start while busy, including during the drain cycle: ignored.
- stop in IDLE: ignored. start and stop in the same cycle while IDLE: start honoured.
- Changing last_addr or loop_count during PLAY has no effect until the next start.
- reset mid-playback: all outputs return to reset values on the next cycle, with no done pulse.

Test Plan:
- Write words 0..3 with sample0 = 0x0100+addr; set last_addr = 3, loop_count = 1; start in cycle n -> dac_data sample0 = 0x0100, 0x0101, 0x0102, 0x0103 at n+2..n+5; valid low and data 0 at n+6; done = 1 only at n+6; busy high n+1..n+5.
- Same memory with loop_count = 3 -> 12 contiguous valid words 0,1,2,3 repeated, no gaps, then one done pulse; start pulses during playback are ignored.
- last_addr = 0, loop_count = 0 (word 0x7FFF in all lanes) -> continuous 0x7FFF; stop in cycle m -> last valid word at m+1, dac_data = 0 from m+2, done at m+2.
- During infinite play over addresses 0..7, write 0xAAAA to address 5 -> next pass outputs 0xAAAA at address 5; a write colliding with a read of the same address shows the old value on that pass.
- Assert reset mid-play at pass 2 -> next cycle dac_data = 0, valid/busy/done = 0; restart with no rewrite replays the preserved memory contents.
- start and stop high together in IDLE -> playback starts normally, word 0 appears at n+2.

Source files
------------

// File: rtl/dac_waveform_player.sv
// dac_waveform_player
//
// Arbitrary-waveform playback engine feeding the DAC monitor/AXIS stage.
// A loader fills an internal block RAM with multi-sample words through a
// simple write port. On start the engine replays words 0..last_addr at one
// word per clock, either loop_count times or forever (loop_count = 0).
// Outside playback the output word is zero, which is mid-scale for
// two's-complement DAC codes.
//
// Ports:
//   clock          single clock for the whole block
//   reset          synchronous, active-high reset
//   wr_en          waveform memory write strobe (accepted in any state)
//   wr_addr        waveform memory write address
//   wr_data        waveform memory write word, sample 0 in bits [15:0]
//   last_addr      final waveform address, captured on start
//   loop_count     number of passes (0 = infinite), captured on start
//   start          level-sampled start, honoured only when idle and not draining
//   stop           abort, honoured only while playing
//   dac_data       word to the DAC stage, forced to zero when not valid
//   dac_data_valid dac_data carries a waveform word
//   busy           playing, or the final word is still on the output
//   done           one-cycle pulse on the first cycle busy is low again
//
// Timing: an address issued in cycle c is on dac_data in cycle c+1, so a
// start seen in cycle n gives word 0 in cycle n+2.

module dac_waveform_player #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [16*NUMBER_OF_LINE-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0]          last_addr,
  input  logic [15:0]                    loop_count,
  input  logic                           start,
  input  logic                           stop,
  output logic [16*NUMBER_OF_LINE-1:0]   dac_data,
  output logic                           dac_data_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int DW    = 16 * NUMBER_OF_LINE;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [15:0]           loop_q, loop_d;
  logic [15:0]           pass_q, pass_d;
  logic                  valid_q, valid_d;
  logic                  busy_prev_q, busy_prev_d;

  logic                  busy_now;
  logic                  final_pass;

  // Waveform memory: simple dual-port with a registered read. Both the write
  // and the read live in one clocked block so a same-address collision
  // returns the old word (read-first). Contents are deliberately left out of
  // reset so a waveform survives a reset.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr_q];
  end

  // Next-state logic. The address held in rd_addr_q while in PLAY is the
  // address issued this cycle; its word is valid one cycle later.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    last_d      = last_q;
    loop_d      = loop_q;
    pass_d      = pass_q;

    busy_now    = (state_q == S_PLAY) || valid_q;
    final_pass  = (loop_q != 16'd0) && ((pass_q + 16'd1) == loop_q);
    valid_d     = (state_q == S_PLAY);
    busy_prev_d = busy_now;

    case (state_q)
      S_IDLE: begin
        // valid_q high in IDLE is the drain cycle; start is ignored there.
        if (start && !valid_q) begin
          state_d   = S_PLAY;
          last_d    = last_addr;
          loop_d    = loop_count;
          pass_d    = 16'd0;
          rd_addr_d = ADDR_ZERO;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (rd_addr_q == last_q) begin
          if (final_pass) begin
            state_d = S_IDLE;
          end else begin
            // In infinite mode the pass counter is free-running.
            rd_addr_d = ADDR_ZERO;
            pass_d    = pass_q + 16'd1;
          end
        end else begin
          rd_addr_d = rd_addr_q + ADDR_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= ADDR_ZERO;
      last_q      <= ADDR_ZERO;
      loop_q      <= 16'd0;
      pass_q      <= 16'd0;
      valid_q     <= 1'b0;
      busy_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      pass_q      <= pass_d;
      valid_q     <= valid_d;
      busy_prev_q <= busy_prev_d;
    end
  end

  // The read register is not reset, so the word is gated by valid.
  assign dac_data       = valid_q ? rd_data_q : '0;
  assign dac_data_valid = valid_q;
  assign busy           = busy_now;
  // busy_prev_q is cleared by reset, so a reset never produces a done pulse.
  assign done           = busy_prev_q && !busy_now;

endmodule

// File: tb/tb_dac_waveform_player.sv
// tb_dac_waveform_player
//
// Directed bench for dac_waveform_player with hand-computed expected words.
// Inputs change 1 ns after the rising edge and outputs are sampled at the
// same point, so "cycle n" below is the cycle whose closing edge samples
// start; one tick later the bench is looking at cycle n+1.

module tb_dac_waveform_player;

  localparam int NL = 8;
  localparam int AW = 10;
  localparam int DW = 16 * NL;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] last_addr;
  logic [15:0]   loop_count;
  logic          start;
  logic          stop;
  logic [DW-1:0] dac_data;
  logic          dac_data_valid;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  dac_waveform_player #(
    .NUMBER_OF_LINE(NL),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .last_addr     (last_addr),
    .loop_count    (loop_count),
    .start         (start),
    .stop          (stop),
    .dac_data      (dac_data),
    .dac_data_valid(dac_data_valid),
    .busy          (busy),
    .done          (done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // Lane i carries s0 + i so lane ordering is checked as well as sample 0.
  function automatic logic [DW-1:0] mk(input logic [15:0] s0);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < NL; i++) begin
      w[16*i +: 16] = s0 + 16'(i);
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] all_lanes(input logic [15:0] s);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < NL; i++) begin
      w[16*i +: 16] = s;
    end
    return w;
  endfunction

  // Expected word for output index j of the infinite 0..7 run: the write of
  // 0xAAAA to address 5 collides with the pass-0 read, so it shows from pass
  // 1; the write of 0xBBBB to address 2 lands during pass 1 after address 2
  // was read, so it shows from pass 2.
  function automatic logic [DW-1:0] exp_run4(input int j);
    int a;
    int p;
    a = j % 8;
    p = j / 8;
    if (a == 5 && p >= 1) return all_lanes(16'hAAAA);
    if (a == 2 && p >= 2) return all_lanes(16'hBBBB);
    return mk(16'h0100 + 16'(a));
  endfunction

  function automatic logic [DW-1:0] mem_final(input int a);
    if (a == 5) return all_lanes(16'hAAAA);
    if (a == 2) return all_lanes(16'hBBBB);
    return mk(16'h0100 + 16'(a));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic v, input logic b, input logic d);
    check_eq({tag, "_valid"}, DW'(dac_data_valid), DW'(v));
    check_eq({tag, "_busy"},  DW'(busy),           DW'(b));
    check_eq({tag, "_done"},  DW'(done),           DW'(d));
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // ---------------- stimulus + checking ----------------
  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    last_addr  = '0;
    loop_count = 16'd0;
    start      = 1'b0;
    stop       = 1'b0;
    tick();
    tick();
    check_eq("reset_data", dac_data, '0);
    check_status("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // ---- Test 1: single pass over 0..3 ----
    for (int a = 0; a < 8; a++) write_word(AW'(a), mk(16'h0100 + 16'(a)));
    last_addr  = AW'(3);
    loop_count = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_n1_data", dac_data, '0);
    check_status("t1_n1", 1'b0, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check_eq($sformatf("t1_word%0d", k - 2), dac_data, mk(16'h0100 + 16'(k - 2)));
      check_status($sformatf("t1_n%0d", k), 1'b1, 1'b1, 1'b0);
    end
    tick();
    check_eq("t1_n6_data", dac_data, '0);
    check_status("t1_n6", 1'b0, 1'b0, 1'b1);
    tick();
    check_status("t1_n7", 1'b0, 1'b0, 1'b0);

    // ---- Test 2: three passes, start pulses and config changes ignored ----
    for (int j = 0; j < 12; j++) exp_q.push_back(mk(16'h0100 + 16'(j % 4)));
    last_addr  = AW'(3);
    loop_count = 16'd3;
    start = 1'b1;
    tick();
    start      = 1'b0;
    last_addr  = AW'(6);
    loop_count = 16'd1;
    check_status("t2_n1", 1'b0, 1'b1, 1'b0);
    for (int k = 2; k <= 13; k++) begin
      tick();
      check_eq($sformatf("t2_n%0d_valid", k), DW'(dac_data_valid), DW'(1));
      if (exp_q.size() != 0) begin
        check_eq($sformatf("t2_n%0d_data", k), dac_data, exp_q.pop_front());
      end
      check_eq($sformatf("t2_n%0d_done", k), DW'(done), DW'(0));
      // Held high through the drain cycle (n+13), where it must be ignored.
      start = (k >= 3) ? 1'b1 : 1'b0;
    end
    tick();
    start = 1'b0;
    check_eq("t2_n14_data", dac_data, '0);
    check_status("t2_n14", 1'b0, 1'b0, 1'b1);
    tick();
    check_status("t2_n15_no_restart", 1'b0, 1'b0, 1'b0);
    check_eq("t2_queue_empty", DW'(exp_q.size()), DW'(0));

    // ---- stop while idle is ignored ----
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_status("idle_stop", 1'b0, 1'b0, 1'b0);

    // ---- Test 3: single word forever, then stop ----
    write_word(AW'(0), all_lanes(16'h7FFF));
    last_addr  = AW'(0);
    loop_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      tick();
      check_eq($sformatf("t3_n%0d_data", k), dac_data, all_lanes(16'h7FFF));
      check_eq($sformatf("t3_n%0d_valid", k), DW'(dac_data_valid), DW'(1));
      if (k == 20) stop = 1'b1;
    end
    tick();
    stop = 1'b0;
    check_eq("t3_m1_data", dac_data, all_lanes(16'h7FFF));
    check_status("t3_m1", 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("t3_m2_data", dac_data, '0);
    check_status("t3_m2", 1'b0, 1'b0, 1'b1);
    tick();
    check_status("t3_m3", 1'b0, 1'b0, 1'b0);

    // ---- Test 4: infinite 0..7 with writes during play, then reset ----
    write_word(AW'(0), mk(16'h0100));
    last_addr  = AW'(7);
    loop_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      tick();
      wr_en = 1'b0;
      check_eq($sformatf("t4_j%0d_data", k - 2), dac_data, exp_run4(k - 2));
      check_status($sformatf("t4_n%0d", k), 1'b1, 1'b1, 1'b0);
      if (k == 6) begin
        // address 5 is being read in this cycle (collision)
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = all_lanes(16'hAAAA);
      end
      if (k == 15) begin
        wr_en   = 1'b1;
        wr_addr = AW'(2);
        wr_data = all_lanes(16'hBBBB);
      end
      if (k == 20) reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    check_eq("t4_reset_data", dac_data, '0);
    check_status("t4_reset", 1'b0, 1'b0, 1'b0);
    tick();
    check_status("t4_after_reset", 1'b0, 1'b0, 1'b0);

    // ---- Test 5: restart without rewrite, memory preserved ----
    last_addr  = AW'(7);
    loop_count = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      check_eq($sformatf("t5_word%0d", k - 2), dac_data, mem_final(k - 2));
      check_eq($sformatf("t5_n%0d_valid", k), DW'(dac_data_valid), DW'(1));
    end
    tick();
    check_status("t5_end", 1'b0, 1'b0, 1'b1);

    // ---- Test 6: start and stop together while idle ----
    last_addr  = AW'(3);
    loop_count = 16'd1;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_status("t6_n1", 1'b0, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check_eq($sformatf("t6_word%0d", k - 2), dac_data, mem_final(k - 2));
      check_eq($sformatf("t6_n%0d_valid", k), DW'(dac_data_valid), DW'(1));
    end
    tick();
    check_status("t6_n6", 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
